// File: rtl/race_sequencer.sv
// race_sequencer: game-flow FSM for the LED racer; owns screen enables,
// countdown digit, race gating, winner latch and the position-clear pulse.
module race_sequencer #(
   parameter int MAX_POS         = 109,
   parameter int TICKS_PER_STEP  = 12_000_000,
   parameter int COUNTDOWN_STEPS = 3,
   parameter int END_HOLD_STEPS  = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_btn,
   input  logic [$clog2(MAX_POS)-1:0] red_pos,
   input  logic [$clog2(MAX_POS)-1:0] blue_pos,
   input  logic [$clog2(MAX_POS)-1:0] green_pos,
   input  logic [$clog2(MAX_POS)-1:0] yellow_pos,
   output logic                       start_screen_en,
   output logic                       countdown_screen_en,
   output logic                       game_screen_en,
   output logic                       end_screen_en,
   output logic [1:0]                 countdown_value,
   output logic                       race_active,
   output logic [2:0]                 winner,
   output logic                       clear_positions
);
   localparam int PW = $clog2(MAX_POS);
   localparam int TW = TICKS_PER_STEP > 1 ? $clog2(TICKS_PER_STEP) : 1;
   localparam int HW = $clog2(END_HOLD_STEPS + 2);
   localparam logic [PW-1:0] FIN = PW'(MAX_POS - 1);
   typedef enum logic [2:0] {S_START, S_COUNTDOWN, S_RACE, S_END, S_CLEAR} state_t;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    cd_q, cd_d;
   logic [2:0]    win_q, win_d, fin_win;
   logic          start_btn_q, btn_rise, step_done, hold_done;
   always_comb begin
      btn_rise  = start_btn & ~start_btn_q;
      step_done = timer_q == TW'(TICKS_PER_STEP - 1);
      hold_done = hold_q == HW'(END_HOLD_STEPS);
      fin_win   = green_pos == FIN ? 3'd1 : red_pos == FIN ? 3'd2 :
                  blue_pos == FIN ? 3'd3 : yellow_pos == FIN ? 3'd4 : 3'd0;
      state_d   = state_q;
      cd_d      = cd_q;
      win_d     = win_q;
      case (state_q)
         S_START: if (btn_rise) begin
            state_d = S_COUNTDOWN;
            cd_d    = 2'(COUNTDOWN_STEPS);
         end
         S_COUNTDOWN: if (step_done) begin
            cd_d    = cd_q > 2'd1 ? cd_q - 2'd1 : 2'd0;
            state_d = cd_q > 2'd1 ? S_COUNTDOWN : S_RACE;
         end
         S_RACE: if (fin_win != 3'd0) begin
            state_d = S_END;
            win_d   = fin_win;
         end
         S_END: if (hold_done && btn_rise) begin
            state_d = S_CLEAR;
            win_d   = 3'd0;
         end
         default: state_d = S_START;
      endcase
      // timer restarts on every state entry so each state sees full steps
      timer_d = (state_d != state_q || step_done) ? '0 : timer_q + TW'(1);
      hold_d  = state_q != S_END ? '0 : (step_done && !hold_done) ? hold_q + HW'(1) : hold_q;
   end
   always_ff @(posedge clk) begin
      start_btn_q <= start_btn;
      if (rst) begin
         state_q <= S_START;
         timer_q <= '0;
         hold_q  <= '0;
         cd_q    <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         hold_q  <= hold_d;
         cd_q    <= cd_d;
         win_q   <= win_d;
      end
   end
   assign start_screen_en     = state_q == S_START;
   assign countdown_screen_en = state_q == S_COUNTDOWN;
   assign game_screen_en      = state_q == S_RACE;
   assign end_screen_en       = state_q == S_END;
   assign race_active         = state_q == S_RACE;
   assign clear_positions     = state_q == S_CLEAR;
   assign countdown_value     = cd_q;
   assign winner              = win_q;
endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer: directed stimulus with a cycle-tagged scoreboard of
// expected output vectors checked by an independent negedge monitor.
module tb_race_sequencer;
   logic       clk = 0, rst = 1, start_btn = 0;
   logic [6:0] red_pos = 0, blue_pos = 0, green_pos = 0, yellow_pos = 0;
   logic       start_screen_en, countdown_screen_en, game_screen_en, end_screen_en;
   logic [1:0] countdown_value;
   logic       race_active, clear_positions;
   logic [2:0] winner;
   int         cyc = 0, n_chk = 0, n_fail = 0;
   bit         done = 0;
   typedef struct {int c; logic [10:0] v; string n;} exp_t;
   exp_t q[$];

   race_sequencer #(.MAX_POS(109), .TICKS_PER_STEP(4), .COUNTDOWN_STEPS(3), .END_HOLD_STEPS(2)) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn),
      .red_pos(red_pos), .blue_pos(blue_pos), .green_pos(green_pos), .yellow_pos(yellow_pos),
      .start_screen_en(start_screen_en), .countdown_screen_en(countdown_screen_en),
      .game_screen_en(game_screen_en), .end_screen_en(end_screen_en),
      .countdown_value(countdown_value), .race_active(race_active),
      .winner(winner), .clear_positions(clear_positions));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // vector layout: start,countdown,game,end,cd_value[2],race_active,winner[3],clear
   function automatic logic [10:0] e(bit s, bit c, bit g, bit n, logic [1:0] cv, bit ra, logic [2:0] w, bit cl);
      return {s, c, g, n, cv, ra, w, cl};
   endfunction
   localparam logic [10:0] ST = 11'b1000_00_0_000_0;
   localparam logic [10:0] RC = 11'b0010_00_1_000_0;
   localparam logic [10:0] CL = 11'b0000_00_0_000_1;

   wire logic [10:0] act = {start_screen_en, countdown_screen_en, game_screen_en, end_screen_en,
                            countdown_value, race_active, winner, clear_positions};

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         n_chk++;
         if (q[0].c < cyc || act !== q[0].v) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %b expected %b", q[0].n, cyc, act, q[0].v);
         end
         void'(q.pop_front());
      end
      if (done && q.size() > 0) begin
         n_fail += q.size();
         $display("FAIL leftover: %0d expectations never checked", q.size());
         q.delete();
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(int d, logic [10:0] v, string n);
      q.push_back('{cyc + d, v, n});
   endtask

   // from S_START with start_btn low; returns in the first S_RACE cycle
   task automatic start_race(bit detail);
      start_btn = 1;
      if (detail) begin
         chk(1, e(0,1,0,0,3,0,0,0), "cd3_entry");
         chk(4, e(0,1,0,0,3,0,0,0), "cd3_last");
         chk(5, e(0,1,0,0,2,0,0,0), "cd2_first");
         chk(8, e(0,1,0,0,2,0,0,0), "cd2_last");
         chk(9, e(0,1,0,0,1,0,0,0), "cd1_first");
         chk(12, e(0,1,0,0,1,0,0,0), "cd1_last");
      end
      chk(13, RC, "race_entry");
      step(1);
      start_btn = 0;
      step(3);
      start_btn = detail;
      step(1);
      start_btn = 0;
      step(8);
   endtask

   // from the S_END entry cycle: press too early, then press once armed
   task automatic end_restart(logic [2:0] w);
      step(5);
      start_btn = 1;
      chk(1, e(0,0,0,1,0,0,w,0), "end_early_press");
      step(1);
      start_btn = 0;
      step(2);
      start_btn = 1;
      chk(0, e(0,0,0,1,0,0,w,0), "end_armed");
      chk(1, CL, "clear_pulse");
      chk(2, ST, "restart_start");
      step(1);
      start_btn = 0;
      {red_pos, blue_pos, green_pos, yellow_pos} = '0;
      step(1);
   endtask

   initial begin
      start_btn = 1;
      step(3);
      chk(0, ST, "reset_state");
      rst = 0;
      for (int i = 1; i <= 20; i++) chk(i, ST, "btn_held_after_reset");
      step(20);
      start_btn = 0;
      step(1);
      start_race(1);
      {red_pos, green_pos, yellow_pos, blue_pos} = {7'd50, 7'd60, 7'd100, 7'd108};
      chk(1, e(0,0,0,1,0,0,3,0), "blue_wins");
      step(1);
      end_restart(3'd3);
      start_race(0);
      {red_pos, yellow_pos} = {7'd108, 7'd108};
      chk(1, e(0,0,0,1,0,0,2,0), "tie_red_over_yellow");
      step(1);
      green_pos = 7'd108;
      chk(1, e(0,0,0,1,0,0,2,0), "late_green_ignored");
      end_restart(3'd2);
      start_race(0);
      {red_pos, blue_pos, green_pos, yellow_pos} = {7'd50, 7'd55, 7'd60, 7'd52};
      chk(1, RC, "race_no_finish");
      step(2);
      rst = 1;
      chk(1, ST, "reset_mid_race");
      step(1);
      rst = 0;
      chk(2, ST, "idle_after_reset");
      step(3);
      done = 1;
      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
